// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Single-port VRAM arbiter. Scan-out reads win every slot; writes
//            come through a 2-entry FIFO; a sequencer can zero-fill the frame.
// Options  : VRAM_STATS_EN adds the drop_cnt / stall_cnt counters.
// Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
    parameter int H_TIME = 794,
    parameter int V_TIME = 523
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [10:0] Fila,
    input  logic [10:0] Columna,
    output logic        Pixel,
    output logic        pix_valid,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [10:0] wr_fila,
    input  logic [10:0] wr_columna,
    input  logic        wr_dato,
    input  logic        clr_req,
    output logic        clr_busy,
    output logic        clr_done,
    output logic [10:0] mem_fila,
    output logic [10:0] mem_columna,
    output logic        mem_we,
    output logic        mem_wdata,
    input  logic        mem_rdata
`ifdef VRAM_STATS_EN
    ,
    output logic [15:0] drop_cnt,
    output logic [15:0] stall_cnt
`endif
);

    localparam logic [10:0] c_h_time = 11'(H_TIME);
    localparam logic [10:0] c_v_time = 11'(V_TIME);
    localparam logic [10:0] c_h_last = 11'(H_TIME - 1);
    localparam logic [10:0] c_v_last = 11'(V_TIME - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t      r_state_q, w_state_d;
    logic [1:0]  r_cnt_q, w_cnt_d;
    logic        r_rd_ptr_q, w_rd_ptr_d;
    logic        r_wr_ptr_q, w_wr_ptr_d;
    logic [22:0] r_fifo_q [2];
    logic [10:0] r_clr_f_q, w_clr_f_d;
    logic [10:0] r_clr_c_q, w_clr_c_d;
    logic [10:0] r_mem_fila_q, w_mem_fila_d;
    logic [10:0] r_mem_col_q, w_mem_col_d;
    logic        r_mem_we_q, w_mem_we_d;
    logic        r_mem_wdata_q, w_mem_wdata_d;
    logic        r_rd_v1_q, r_rd_ok1_q, r_rd_v2_q, r_rd_ok2_q;
    logic        r_pixel_q, r_pix_valid_q;
    logic        r_wr_ready_q, w_wr_ready_d;
    logic        r_clr_busy_q, r_clr_done_q;

    logic        w_rd_take, w_wr_in_range, w_push, w_pop, w_clr_wr, w_clr_last;
    logic [22:0] w_head;

    // Out-of-range reads leave the slot free for the FIFO or the clear sequencer.
    assign w_rd_take     = pix_en && (Fila < c_v_time) && (Columna < c_h_time);
    assign w_wr_in_range = (wr_fila < c_v_time) && (wr_columna < c_h_time);
    assign w_push        = wr_valid && r_wr_ready_q && w_wr_in_range;
    assign w_pop         = !w_rd_take && (r_cnt_q != 2'd0) && (r_state_q != ST_CLEAR);
    assign w_clr_wr      = !w_rd_take && (r_state_q == ST_CLEAR);
    assign w_clr_last    = w_clr_wr && (r_clr_c_q == c_h_last) && (r_clr_f_q == c_v_last);
    assign w_head        = r_fifo_q[r_rd_ptr_q];

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_rd_ptr_d    = r_rd_ptr_q;
        w_wr_ptr_d    = r_wr_ptr_q;
        w_clr_f_d     = r_clr_f_q;
        w_clr_c_d     = r_clr_c_q;
        w_mem_fila_d  = r_mem_fila_q;
        w_mem_col_d   = r_mem_col_q;
        w_mem_we_d    = 1'b0;
        w_mem_wdata_d = 1'b0;

        if (w_push) w_wr_ptr_d = ~r_wr_ptr_q;
        if (w_pop)  w_rd_ptr_d = ~r_rd_ptr_q;
        case ({w_push, w_pop})
            2'b10:   w_cnt_d = r_cnt_q + 2'd1;
            2'b01:   w_cnt_d = r_cnt_q - 2'd1;
            default: w_cnt_d = r_cnt_q;
        endcase

        if (w_rd_take) begin
            w_mem_fila_d = Fila;
            w_mem_col_d  = Columna;
        end else if (w_pop) begin
            w_mem_fila_d  = w_head[22:12];
            w_mem_col_d   = w_head[11:1];
            w_mem_we_d    = 1'b1;
            w_mem_wdata_d = w_head[0];
        end else if (w_clr_wr) begin
            w_mem_fila_d = r_clr_f_q;
            w_mem_col_d  = r_clr_c_q;
            w_mem_we_d   = 1'b1;
        end

        if (w_clr_wr) begin
            if (r_clr_c_q == c_h_last) begin
                w_clr_c_d = 11'd0;
                w_clr_f_d = (r_clr_f_q == c_v_last) ? 11'd0 : r_clr_f_q + 11'd1;
            end else begin
                w_clr_c_d = r_clr_c_q + 11'd1;
            end
        end

        case (r_state_q)
            ST_RUN:   if (clr_req) w_state_d = ST_DRAIN;
            ST_DRAIN: if (r_cnt_q == 2'd0) w_state_d = ST_CLEAR;
            ST_CLEAR: if (w_clr_last) w_state_d = ST_RUN;
            default:  w_state_d = ST_RUN;
        endcase

        w_wr_ready_d = (w_state_d == ST_RUN) && (w_cnt_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_RUN;
            r_cnt_q       <= 2'd0;
            r_rd_ptr_q    <= 1'b0;
            r_wr_ptr_q    <= 1'b0;
            r_clr_f_q     <= 11'd0;
            r_clr_c_q     <= 11'd0;
            r_mem_fila_q  <= 11'd0;
            r_mem_col_q   <= 11'd0;
            r_mem_we_q    <= 1'b0;
            r_mem_wdata_q <= 1'b0;
            r_rd_v1_q     <= 1'b0;
            r_rd_ok1_q    <= 1'b0;
            r_rd_v2_q     <= 1'b0;
            r_rd_ok2_q    <= 1'b0;
            r_pixel_q     <= 1'b0;
            r_pix_valid_q <= 1'b0;
            r_wr_ready_q  <= 1'b0;
            r_clr_busy_q  <= 1'b0;
            r_clr_done_q  <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_rd_ptr_q    <= w_rd_ptr_d;
            r_wr_ptr_q    <= w_wr_ptr_d;
            r_clr_f_q     <= w_clr_f_d;
            r_clr_c_q     <= w_clr_c_d;
            r_mem_fila_q  <= w_mem_fila_d;
            r_mem_col_q   <= w_mem_col_d;
            r_mem_we_q    <= w_mem_we_d;
            r_mem_wdata_q <= w_mem_wdata_d;
            r_rd_v1_q     <= pix_en;
            r_rd_ok1_q    <= w_rd_take;
            r_rd_v2_q     <= r_rd_v1_q;
            r_rd_ok2_q    <= r_rd_ok1_q;
            r_pixel_q     <= r_rd_ok2_q && mem_rdata;
            r_pix_valid_q <= r_rd_v2_q;
            r_wr_ready_q  <= w_wr_ready_d;
            r_clr_busy_q  <= (w_state_d != ST_RUN);
            r_clr_done_q  <= w_clr_last;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo_q[r_wr_ptr_q] <= {wr_fila, wr_columna, wr_dato};
    end

`ifdef VRAM_STATS_EN
    logic [15:0] r_drop_q, r_stall_q;
    logic        w_drop, w_stall;
    assign w_drop  = wr_valid && r_wr_ready_q && !w_wr_in_range;
    assign w_stall = w_rd_take && (r_cnt_q != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_q  <= 16'd0;
            r_stall_q <= 16'd0;
        end else begin
            if (w_drop && (r_drop_q != 16'hFFFF))   r_drop_q  <= r_drop_q + 16'd1;
            if (w_stall && (r_stall_q != 16'hFFFF)) r_stall_q <= r_stall_q + 16'd1;
        end
    end
    assign drop_cnt  = r_drop_q;
    assign stall_cnt = r_stall_q;
`endif

    assign Pixel       = r_pixel_q;
    assign pix_valid   = r_pix_valid_q;
    assign wr_ready    = r_wr_ready_q;
    assign clr_busy    = r_clr_busy_q;
    assign clr_done    = r_clr_done_q;
    assign mem_fila    = r_mem_fila_q;
    assign mem_columna = r_mem_col_q;
    assign mem_we      = r_mem_we_q;
    assign mem_wdata   = r_mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Purpose  : Scoreboard bench for vram_arbiter; full-size and 4x2 instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Full-size instance
    logic        a_pix_en = 1'b0, a_wv = 1'b0, a_wd = 1'b0, a_clr = 1'b0;
    logic [10:0] a_fila = 11'd0, a_col = 11'd0, a_wf = 11'd0, a_wc = 11'd0;
    logic        a_pixel, a_pv, a_wr, a_busy, a_done, a_we, a_wdat;
    logic        a_rdata = 1'b0;
    logic [10:0] a_mf, a_mc;
    // 4x2 instance for the clear sequence
    logic        b_pix_en = 1'b0, b_wv = 1'b0, b_wd = 1'b0, b_clr = 1'b0;
    logic [10:0] b_fila = 11'd0, b_col = 11'd0, b_wf = 11'd0, b_wc = 11'd0;
    logic        b_pixel, b_pv, b_wr, b_busy, b_done, b_we, b_wdat;
    logic        b_rdata = 1'b0;
    logic [10:0] b_mf, b_mc;
`ifdef VRAM_STATS_EN
    logic [15:0] a_drop, a_stall, b_drop, b_stall;
`endif

    vram_arbiter u_a (
        .clk(clk), .rst(rst), .pix_en(a_pix_en), .Fila(a_fila), .Columna(a_col),
        .Pixel(a_pixel), .pix_valid(a_pv), .wr_valid(a_wv), .wr_ready(a_wr),
        .wr_fila(a_wf), .wr_columna(a_wc), .wr_dato(a_wd), .clr_req(a_clr),
        .clr_busy(a_busy), .clr_done(a_done), .mem_fila(a_mf), .mem_columna(a_mc),
        .mem_we(a_we), .mem_wdata(a_wdat), .mem_rdata(a_rdata)
`ifdef VRAM_STATS_EN
        , .drop_cnt(a_drop), .stall_cnt(a_stall)
`endif
    );

    vram_arbiter #(.H_TIME(4), .V_TIME(2)) u_b (
        .clk(clk), .rst(rst), .pix_en(b_pix_en), .Fila(b_fila), .Columna(b_col),
        .Pixel(b_pixel), .pix_valid(b_pv), .wr_valid(b_wv), .wr_ready(b_wr),
        .wr_fila(b_wf), .wr_columna(b_wc), .wr_dato(b_wd), .clr_req(b_clr),
        .clr_busy(b_busy), .clr_done(b_done), .mem_fila(b_mf), .mem_columna(b_mc),
        .mem_we(b_we), .mem_wdata(b_wdat), .mem_rdata(b_rdata)
`ifdef VRAM_STATS_EN
        , .drop_cnt(b_drop), .stall_cnt(b_stall)
`endif
    );

    // RAM model: (5,7) and (0,800) hold 1; the latter must never be read.
    bit ram [0:1023][0:1023];
    always @(posedge clk) begin
        if (rst) begin
            ram[5][7]   <= 1'b1;
            ram[0][800] <= 1'b1;
        end else begin
            a_rdata <= ram[a_mf[9:0]][a_mc[9:0]];
            if (a_we) ram[a_mf[9:0]][a_mc[9:0]] <= a_wdat;
        end
    end

    typedef struct { int cyc; int val; } pix_t;
    typedef struct { int cyc; int f; int c; int d; } wr_t;
    pix_t pix_q[$];
    wr_t  wa_q[$];
    wr_t  wb_q[$];

    function automatic void exp_pix(input int c, input int v);
        pix_t e;
        e.cyc = c; e.val = v;
        pix_q.push_back(e);
    endfunction

    function automatic wr_t mk_wr(input int c, input int f, input int col, input int d);
        wr_t e;
        e.cyc = c; e.f = f; e.c = col; e.d = d;
        return e;
    endfunction

    // Monitors
    pix_t pe;
    wr_t  ea, eb;
    int   a_done_n = 0, b_done_n = 0, b_done_cyc = -1;

    always @(negedge clk) begin
        if (!rst) begin
            if (a_pv) begin
                check("pix_expected", int'(pix_q.size() > 0), 1);
                if (pix_q.size() > 0) begin
                    pe = pix_q.pop_front();
                    check("pix_value", int'(a_pixel), pe.val);
                    check("pix_cycle", cyc, pe.cyc);
                end
            end
            if (a_we) begin
                check("a_we_expected", int'(wa_q.size() > 0), 1);
                if (wa_q.size() > 0) begin
                    ea = wa_q.pop_front();
                    check("a_we_cycle", cyc, ea.cyc);
                    check("a_we_fila", int'(a_mf), ea.f);
                    check("a_we_col", int'(a_mc), ea.c);
                    check("a_we_data", int'(a_wdat), ea.d);
                end
            end
            if (b_we) begin
                check("b_we_expected", int'(wb_q.size() > 0), 1);
                if (wb_q.size() > 0) begin
                    eb = wb_q.pop_front();
                    check("b_we_cycle", cyc, eb.cyc);
                    check("b_we_fila", int'(b_mf), eb.f);
                    check("b_we_col", int'(b_mc), eb.c);
                    check("b_we_data", int'(b_wdat), eb.d);
                end
            end
            if (a_done) a_done_n++;
            if (b_done) begin
                b_done_n++;
                b_done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int t0;
    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pixel", int'(a_pixel), 0);
        check("rst_pix_valid", int'(a_pv), 0);
        check("rst_wr_ready", int'(a_wr), 0);
        check("rst_clr_busy", int'(a_busy), 0);
        check("rst_clr_done", int'(a_done), 0);
        check("rst_mem_fila", int'(a_mf), 0);
        check("rst_mem_col", int'(a_mc), 0);
        check("rst_mem_we", int'(a_we), 0);
        check("rst_mem_wdata", int'(a_wdat), 0);
        rst = 1'b0;
        tick();
        check("post_rst_wr_ready", int'(a_wr), 1);
        check("post_rst_b_wr_ready", int'(b_wr), 1);
        check("post_rst_busy", int'(a_busy), 0);

        // Scan read of (5,7): address next cycle, Pixel=1 three cycles later
        t0 = cyc;
        a_pix_en = 1'b1; a_fila = 11'd5; a_col = 11'd7;
        exp_pix(t0 + 3, 1);
        tick();
        check("rd_mem_fila", int'(a_mf), 5);
        check("rd_mem_col", int'(a_mc), 7);
        check("rd_mem_we", int'(a_we), 0);
        a_pix_en = 1'b0;
        repeat (4) tick();

        // FIFO fill: reads hold the slot so two writes occupy both entries
        t0 = cyc;
        check("fill_ready0", int'(a_wr), 1);
        a_pix_en = 1'b1; a_fila = 11'd1; a_col = 11'd1; exp_pix(t0 + 3, 0);
        a_wv = 1'b1; a_wf = 11'd20; a_wc = 11'd30; a_wd = 1'b1;
        wa_q.push_back(mk_wr(t0 + 3, 20, 30, 1));
        tick();
        check("fill_ready1", int'(a_wr), 1);
        a_col = 11'd2; exp_pix(t0 + 4, 0);
        a_wf = 11'd21; a_wc = 11'd31; a_wd = 1'b0;
        wa_q.push_back(mk_wr(t0 + 4, 21, 31, 0));
        tick();
        check("fill_full_not_ready", int'(a_wr), 0);
        a_pix_en = 1'b0;
        a_wf = 11'd22; a_wc = 11'd32; a_wd = 1'b1;
        tick();
        check("fill_ready_after_drain", int'(a_wr), 1);
        wa_q.push_back(mk_wr(t0 + 5, 22, 32, 1));
        tick();
        a_wv = 1'b0;
        repeat (3) tick();

        // Write deferred by four scan reads
        t0 = cyc;
        check("defer_ready", int'(a_wr), 1);
        a_wv = 1'b1; a_wf = 11'd10; a_wc = 11'd10; a_wd = 1'b1;
        wa_q.push_back(mk_wr(t0 + 6, 10, 10, 1));
        tick();
        a_wv = 1'b0;
        a_pix_en = 1'b1; a_fila = 11'd5; a_col = 11'd7;
        for (int i = 0; i < 4; i++) begin
            exp_pix(cyc + 3, 1);
            tick();
        end
        a_pix_en = 1'b0;
        repeat (4) tick();
`ifdef VRAM_STATS_EN
        check("stall_cnt", int'(a_stall), 5);
`endif

        // Out-of-range write and read
        t0 = cyc;
        check("oor_ready", int'(a_wr), 1);
        a_wv = 1'b1; a_wf = 11'd600; a_wc = 11'd0; a_wd = 1'b1;
        tick();
        check("oor_ready_after", int'(a_wr), 1);
        a_wv = 1'b0;
        a_pix_en = 1'b1; a_fila = 11'd0; a_col = 11'd800;
        exp_pix(t0 + 4, 0);
        tick();
        a_pix_en = 1'b0;
        check("oor_no_ram_access", int'(a_mc == 11'd800), 0);
        repeat (4) tick();
`ifdef VRAM_STATS_EN
        check("drop_cnt", int'(a_drop), 1);
`endif

        // 4x2 clear: pending write drained first, then 8 zero writes
        t0 = cyc;
        check("clr_ready0", int'(b_wr), 1);
        b_wv = 1'b1; b_wf = 11'd1; b_wc = 11'd2; b_wd = 1'b1; b_clr = 1'b1;
        wb_q.push_back(mk_wr(t0 + 2, 1, 2, 1));
        for (int k = 0; k < 8; k++) wb_q.push_back(mk_wr(t0 + 4 + k, k / 4, k % 4, 0));
        tick();
        b_wv = 1'b0; b_clr = 1'b0;
        check("clr_busy_drain", int'(b_busy), 1);
        check("clr_ready_drain", int'(b_wr), 0);
        repeat (4) tick();
        check("clr_ready_clear", int'(b_wr), 0);
        b_clr = 1'b1;
        tick();
        b_clr = 1'b0;
        repeat (5) tick();
        check("clr_busy_end", int'(b_busy), 0);
        check("clr_ready_end", int'(b_wr), 1);
        repeat (6) tick();

        check("pix_q_left", pix_q.size(), 0);
        check("a_wr_q_left", wa_q.size(), 0);
        check("b_wr_q_left", wb_q.size(), 0);
        check("a_clr_done_count", a_done_n, 0);
        check("b_clr_done_count", b_done_n, 1);
        check("b_clr_done_cycle", b_done_cyc, t0 + 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
